mux_nx1_pipe: RTL and testbench
===============================

// Module: mux_nx1_pipe
// PURPOSE
//   Parametrised N:1 word multiplexer with a valid/ready handshake and a 2-entry
//   registered output (skid) stage. Next-generation datapath select mux for the
//   SPARC core: generalised width/input count, fully registered, backpressure-safe.
//   Sits between operand/result sources and pipeline-stage registers.
// PARAMETERS
//   WIDTH  32  data width of each input channel and of out_data
//   N      4   number of input channels, >= 2
//   SELW   $clog2(N)  select width; localparam, derived, not overridable
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_data    in   N*WIDTH   channel k at in_data[k*WIDTH +: WIDTH]
//   in_sel     in   SELW      channel select, sampled on accept
//   in_valid   in   1         upstream offers a transfer
//   in_ready   out  1         block can accept; registered
//   out_data   out  WIDTH     selected word, head of buffer
//   out_valid  out  1         out_data valid
//   out_ready  in   1         downstream consumes when out_valid & out_ready
//   sel_err    out  1         only with MUX_SEL_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//   - Reset (rst_n=0, async): out_valid=0, out_data=0, in_ready=1, sel_err=0, state EMPTY.
//     Reset mid-transfer discards both buffered words; no partial output.
//   - accept = in_valid & in_ready; pop = out_valid & out_ready.
//   - Data captured on accept = in_data[in_sel*WIDTH +: WIDTH]; in_sel >= N -> see CONFIG.
//   - Latency: accept in cycle t -> out_valid=1 with that word in cycle t+1 (buffer empty).
//   - FSM (count of held words): EMPTY(0), ONE(1), FULL(2).
//       EMPTY: accept -> ONE.
//       ONE:   accept&!pop -> FULL (word into skid reg); pop&!accept -> EMPTY;
//              accept&pop -> ONE (new word into head reg).
//       FULL:  in_ready=0, no accept; pop -> ONE (skid word moves to head).
//   - in_ready = (state != FULL), driven from a register; never combinational from out_ready.
//   - out_valid = (state != EMPTY); out_data stable while out_valid & !out_ready.
//   - Ordering strictly FIFO; no word dropped or duplicated under any valid/ready pattern.
//   - in_valid with in_ready=0 is ignored; upstream holds in_data/in_sel until accepted.
//   - out_data holds last value when EMPTY (not cleared except by reset).
// CONFIGURATION
//   Macro MUX_SEL_CHECK_EN:
//   - Defined: in_sel >= N on accept -> transfer consumed (handshake completes) but
//     no word enters the buffer; sel_err=1 for exactly the following cycle; FSM unchanged.
//   - Not defined: in_sel >= N selects all-zero word, forwarded normally; sel_err tied 0.
//   - N a power of two: in_sel >= N impossible; both builds behave identically.
// TESTING
//   T1 reset: hold rst_n=0, toggle inputs -> out_valid=0, out_data=0, in_ready=1.
//   T2 single: WIDTH=32,N=4, I2=32'hDEAD_BEEF, in_sel=2, 1-cycle valid, out_ready=1 ->
//      out_valid=1, out_data=32'hDEAD_BEEF next cycle only.
//   T3 backpressure: out_ready=0, send sel 0,1,2 back-to-back -> in_ready=0 after 2nd
//      accept, 3rd held; then out_ready=1 -> outputs I0,I1,I2 in order, no loss.
//   T4 simultaneous: state ONE, accept+pop same cycle for 100 cycles random sel ->
//      throughput 1 word/cycle, in_ready stays 1, scoreboard match.
//   T5 reset mid-op: FULL, assert rst_n=0 asynchronously mid-cycle -> outputs reset
//      immediately, no buffered word emitted after release.
//   T6 range (N=5, SELW=3): in_sel=7 with macro -> no out_valid, sel_err=1 one cycle;
//      without macro -> out_data=0 forwarded, sel_err=0.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// N:1 word multiplexer with valid/ready handshake and a 2-entry registered skid stage.
// Optional macro MUX_SEL_CHECK_EN: out-of-range selects are consumed, dropped and flagged on sel_err.
module mux_nx1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_pop;
  logic             w_load;

  // Unmatched select values leave the word at zero.
  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(in_sel) == k) w_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

`ifdef MUX_SEL_CHECK_EN
  logic w_sel_ok;
  logic r_sel_err;

  assign w_sel_ok = 32'(in_sel) < 32'(N);
  assign w_load   = w_accept & w_sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sel_err <= 1'b0;
    else        r_sel_err <= w_accept & ~w_sel_ok;
  end

  assign sel_err = r_sel_err;
`else
  assign w_load  = w_accept;
  assign sel_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY: if (w_load) w_next = ONE;
      ONE: begin
        if (w_load && !w_pop)      w_next = FULL;
        else if (!w_load && w_pop) w_next = EMPTY;
      end
      FULL:    if (w_pop) w_next = ONE;
      default: w_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state != EMPTY);
    in_ready  = r_in_ready;
    out_data  = r_head;
  end

  // in_ready is precomputed from the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_in_ready <= 1'b1;
    else        r_in_ready <= (w_next != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      unique case (r_state)
        EMPTY: if (w_load) r_head <= w_word;
        ONE: begin
          if (w_load && !w_pop)     r_skid <= w_word;
          else if (w_load && w_pop) r_head <= w_word;
        end
        FULL:    if (w_pop) r_head <= r_skid;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed self-checking bench for mux_nx1_pipe: N=4 main instance plus an N=5 instance for select range.
module tb_mux_nx1_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [4*W-1:0] in_data;
  logic [1:0]     in_sel;
  logic           in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [W-1:0]   out_data;

  logic [5*W-1:0] in_data5;
  logic [2:0]     in_sel5;
  logic           in_valid5, in_ready5, out_valid5, out_ready5, sel_err5;
  logic [W-1:0]   out_data5;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] words [5];

  mux_nx1_pipe #(.WIDTH(W), .N(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_nx1_pipe #(.WIDTH(W), .N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_sel(in_sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .sel_err(sel_err5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are sampled at the next rising edge; outputs are checked at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'hDEAD_BEEF;
    words[3] = 32'h4444_4444;
    words[4] = 32'h5555_5555;
    in_data  = {words[3], words[2], words[1], words[0]};
    in_data5 = {words[4], words[3], words[2], words[1], words[0]};
    in_sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
    in_sel5 = 3'd0; in_valid5 = 1'b0; out_ready5 = 1'b0;

    // T1: inputs toggling under reset have no effect
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid; in_sel = in_sel + 2'd1; out_ready = ~out_ready;
      in_valid5 = ~in_valid5;
      step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
    end
    chk("rst_in_ready5", {63'd0, in_ready5}, 64'd1);
    in_valid = 1'b0; out_ready = 1'b0; in_valid5 = 1'b0;
    rst_n = 1'b1;
    step();

    // T2: single transfer, visible for exactly one cycle
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    step();
    chk("t2_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_data", {32'd0, out_data}, {32'd0, 32'hDEAD_BEEF});
    chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    step();
    chk("t2_valid_off", {63'd0, out_valid}, 64'd0);
    chk("t2_data_hold", {32'd0, out_data}, {32'd0, 32'hDEAD_BEEF});

    // T3: backpressure fills both entries, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    step();
    chk("t3_a_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_a_data", {32'd0, out_data}, {32'd0, words[0]});
    chk("t3_a_ready", {63'd0, in_ready}, 64'd1);
    in_sel = 2'd1;
    step();
    chk("t3_full_ready", {63'd0, in_ready}, 64'd0);
    chk("t3_full_data", {32'd0, out_data}, {32'd0, words[0]});
    in_sel = 2'd2;
    step();
    chk("t3_held_ready", {63'd0, in_ready}, 64'd0);
    chk("t3_held_data", {32'd0, out_data}, {32'd0, words[0]});
    out_ready = 1'b1;
    step();
    chk("t3_d1_data", {32'd0, out_data}, {32'd0, words[1]});
    chk("t3_d1_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("t3_d2_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_d2_data", {32'd0, out_data}, {32'd0, words[2]});
    in_valid = 1'b0;
    step();
    chk("t3_empty", {63'd0, out_valid}, 64'd0);

    // T4: one accept and one pop every cycle for 100 cycles
    in_valid = 1'b1; out_ready = 1'b1; in_sel = 2'd3;
    step();
    begin
      logic [1:0] prev_sel;
      prev_sel = 2'd3;
      for (int i = 0; i < 100; i++) begin
        in_sel = 2'((i * 3 + 1) % 4);
        chk("t4_data", {32'd0, out_data}, {32'd0, words[prev_sel]});
        chk("t4_valid", {63'd0, out_valid}, 64'd1);
        chk("t4_ready", {63'd0, in_ready}, 64'd1);
        prev_sel = in_sel;
        step();
      end
      chk("t4_last", {32'd0, out_data}, {32'd0, words[prev_sel]});
    end
    in_valid = 1'b0;
    step();
    chk("t4_empty", {63'd0, out_valid}, 64'd0);

    // T5: asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    step();
    in_sel = 2'd3;
    step();
    chk("t5_full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_async_data", {32'd0, out_data}, 64'd0);
    chk("t5_async_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_ghost", {63'd0, out_valid}, 64'd0);
    end

    // T6: N=5 instance, valid channel 4 then out-of-range select 7
    in_valid5 = 1'b1; in_sel5 = 3'd4; out_ready5 = 1'b1;
    step();
    chk("t6_ch4_data", {32'd0, out_data5}, {32'd0, words[4]});
    chk("t6_ch4_valid", {63'd0, out_valid5}, 64'd1);
    in_sel5 = 3'd7;
    step();
    in_valid5 = 1'b0;
`ifdef MUX_SEL_CHECK_EN
    chk("t6_bad_valid", {63'd0, out_valid5}, 64'd0);
    chk("t6_bad_err", {63'd0, sel_err5}, 64'd1);
    chk("t6_bad_hold", {32'd0, out_data5}, {32'd0, words[4]});
    chk("t6_bad_ready", {63'd0, in_ready5}, 64'd1);
    step();
    chk("t6_err_clear", {63'd0, sel_err5}, 64'd0);
    chk("t6_still_empty", {63'd0, out_valid5}, 64'd0);
`else
    chk("t6_bad_valid", {63'd0, out_valid5}, 64'd1);
    chk("t6_bad_data", {32'd0, out_data5}, 64'd0);
    chk("t6_bad_err", {63'd0, sel_err5}, 64'd0);
    step();
    chk("t6_err_clear", {63'd0, sel_err5}, 64'd0);
    chk("t6_drained", {63'd0, out_valid5}, 64'd0);
`endif
    chk("t6_main_err", {63'd0, sel_err}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
